// File: rtl/exe_pkg.sv
// exe_pkg: ALU op codes, multiply FSM states and op helpers shared by the execute stage.
package exe_pkg;
  localparam logic [3:0] ALUC_AND   = 4'b0000;
  localparam logic [3:0] ALUC_OR    = 4'b0001;
  localparam logic [3:0] ALUC_ADD   = 4'b0010;
  localparam logic [3:0] ALUC_XOR   = 4'b0011;
  localparam logic [3:0] ALUC_SUB   = 4'b0110;
  localparam logic [3:0] ALUC_SLT   = 4'b0111;
  localparam logic [3:0] ALUC_SLL   = 4'b1000;
  localparam logic [3:0] ALUC_SRL   = 4'b1001;
  localparam logic [3:0] ALUC_SRA   = 4'b1010;
  localparam logic [3:0] ALUC_NOR   = 4'b1100;
  localparam logic [3:0] ALUC_MUL   = 4'b1101;
  localparam logic [3:0] ALUC_MULHU = 4'b1110;

  typedef enum logic {IDLE, MUL_BUSY} state_t;

  function automatic logic is_mul(input logic [3:0] aluc);
    return aluc == ALUC_MUL || aluc == ALUC_MULHU;
  endfunction
endpackage

// File: rtl/exe_stage_mc_iter_multiplier.sv
// iter_multiplier: unsigned shift-add multiplier retiring MUL_BITS_PER_CYCLE multiplier bits per busy cycle.
module iter_multiplier #(
  parameter int XLEN = 32,
  parameter int MUL_BITS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [2*XLEN-1:0] product
);
  localparam int K  = MUL_BITS_PER_CYCLE;
  localparam int N  = XLEN / K;
  localparam int CW = $clog2(N + 1);
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CW-1:0]     count_q, count_d;
  logic [XLEN+K-1:0] sum;
  assign busy    = count_q != '0;
  assign done    = count_q == CW'(1);
  assign product = {sum, acc_q[XLEN-1:K]};
  // Low half of acc starts as the multiplier and is shifted out as partial sums enter the high half.
  always_comb begin
    sum     = {{K{1'b0}}, acc_q[2*XLEN-1:XLEN]} + (XLEN+K)'(mcand_q) * (XLEN+K)'(acc_q[K-1:0]);
    acc_d   = start ? {{XLEN{1'b0}}, b} : busy ? product : acc_q;
    mcand_d = start ? a : mcand_q;
    count_d = start ? CW'(N) : busy ? count_q - CW'(1) : count_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q <= '0;
      acc_q   <= '0;
      count_q <= '0;
    end else begin
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/exe_stage_mc.sv
// exe_stage_mc: execute stage with single-cycle ALU, iterative multiplier and EXE/MEM pipeline register.
module exe_stage_mc
  import exe_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int REG_ADDR_W = 5,
  parameter int MUL_BITS_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  ewreg,
  input  logic                  em2reg,
  input  logic                  ewmem,
  input  logic                  ealuimm,
  input  logic [3:0]            ealuc,
  input  logic [REG_ADDR_W-1:0] RdRtin,
  input  logic [XLEN-1:0]       qa,
  input  logic [XLEN-1:0]       qb,
  input  logic [XLEN-1:0]       extended,
  output logic                  out_valid,
  output logic                  wregout,
  output logic                  m2regout,
  output logic                  wmemout,
  output logic [REG_ADDR_W-1:0] RdRtout,
  output logic [XLEN-1:0]       qbout,
  output logic [XLEN-1:0]       aluout
);
  localparam int SH = $clog2(XLEN);
  state_t state_q, state_d;
  logic [XLEN-1:0] b_op, alu_res;
  logic [SH-1:0] sh;
  logic accept, mul_start, mul_busy, mul_done_raw, mul_done;
  logic [2*XLEN-1:0] product;
  logic l_wreg_q, l_wreg_d, l_m2reg_q, l_m2reg_d, l_wmem_q, l_wmem_d, l_hi_q, l_hi_d;
  logic [REG_ADDR_W-1:0] l_rd_q, l_rd_d;
  logic [XLEN-1:0] l_qb_q, l_qb_d;
  logic ov_q, ov_d, wreg_q, wreg_d, m2reg_q, m2reg_d, wmem_q, wmem_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0] qbo_q, qbo_d, alu_q, alu_d;

  assign b_op      = ealuimm ? extended : qb;
  assign sh        = qa[SH-1:0];
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && is_mul(ealuc);
  assign mul_done  = state_q == MUL_BUSY && mul_busy && mul_done_raw;

  iter_multiplier #(.XLEN(XLEN), .MUL_BITS_PER_CYCLE(MUL_BITS_PER_CYCLE)) u_mul (
    .clk(clk), .rst(rst), .start(mul_start), .a(qa), .b(b_op),
    .busy(mul_busy), .done(mul_done_raw), .product(product)
  );

  always_comb begin
    case (ealuc)
      ALUC_AND: alu_res = qa & b_op;
      ALUC_OR:  alu_res = qa | b_op;
      ALUC_XOR: alu_res = qa ^ b_op;
      ALUC_NOR: alu_res = ~(qa | b_op);
      ALUC_ADD: alu_res = qa + b_op;
      ALUC_SUB: alu_res = qa - b_op;
      ALUC_SLT: alu_res = {{(XLEN-1){1'b0}}, $signed(qa) < $signed(b_op)};
      ALUC_SLL: alu_res = b_op << sh;
      ALUC_SRL: alu_res = b_op >> sh;
      ALUC_SRA: alu_res = $signed(b_op) >>> sh;
      default:  alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && mul_start) state_d = MUL_BUSY;
    else if (mul_done)                state_d = IDLE;
  end

  assign in_ready = state_q == IDLE;

  always_comb begin
    l_wreg_d  = mul_start ? ewreg : l_wreg_q;
    l_m2reg_d = mul_start ? em2reg : l_m2reg_q;
    l_wmem_d  = mul_start ? ewmem : l_wmem_q;
    l_hi_d    = mul_start ? ealuc == ALUC_MULHU : l_hi_q;
    l_rd_d    = mul_start ? RdRtin : l_rd_q;
    l_qb_d    = mul_start ? qb : l_qb_q;
  end

  // Bubbles clear the valid and write enables but leave data fields holding.
  always_comb begin
    ov_d    = 1'b0;
    wreg_d  = 1'b0;
    wmem_d  = 1'b0;
    m2reg_d = m2reg_q;
    rd_d    = rd_q;
    qbo_d   = qbo_q;
    alu_d   = alu_q;
    if (accept && !is_mul(ealuc)) begin
      ov_d    = 1'b1;
      wreg_d  = ewreg;
      m2reg_d = em2reg;
      wmem_d  = ewmem;
      rd_d    = RdRtin;
      qbo_d   = qb;
      alu_d   = alu_res;
    end else if (mul_done) begin
      ov_d    = 1'b1;
      wreg_d  = l_wreg_q;
      m2reg_d = l_m2reg_q;
      wmem_d  = l_wmem_q;
      rd_d    = l_rd_q;
      qbo_d   = l_qb_q;
      alu_d   = l_hi_q ? product[2*XLEN-1:XLEN] : product[XLEN-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      l_wreg_q <= 1'b0; l_m2reg_q <= 1'b0; l_wmem_q <= 1'b0; l_hi_q <= 1'b0;
      l_rd_q <= '0; l_qb_q <= '0;
      ov_q <= 1'b0; wreg_q <= 1'b0; m2reg_q <= 1'b0; wmem_q <= 1'b0;
      rd_q <= '0; qbo_q <= '0; alu_q <= '0;
    end else begin
      l_wreg_q <= l_wreg_d; l_m2reg_q <= l_m2reg_d; l_wmem_q <= l_wmem_d; l_hi_q <= l_hi_d;
      l_rd_q <= l_rd_d; l_qb_q <= l_qb_d;
      ov_q <= ov_d; wreg_q <= wreg_d; m2reg_q <= m2reg_d; wmem_q <= wmem_d;
      rd_q <= rd_d; qbo_q <= qbo_d; alu_q <= alu_d;
    end
  end

  assign out_valid = ov_q;
  assign wregout   = wreg_q;
  assign m2regout  = m2reg_q;
  assign wmemout   = wmem_q;
  assign RdRtout   = rd_q;
  assign qbout     = qbo_q;
  assign aluout    = alu_q;
endmodule

// File: tb/tb_exe_stage_mc.sv
// tb_exe_stage_mc: directed checks of ALU ops, multi-cycle multiply, stalls, bubbles and reset abort.
module tb_exe_stage_mc;
  logic clk = 1'b0, rst = 1'b1, iv = 1'b0, iv4 = 1'b0;
  logic ewreg = 1'b0, em2reg = 1'b0, ewmem = 1'b0, ealuimm = 1'b0;
  logic [3:0] ealuc = 4'b0;
  logic [4:0] rdin = 5'd0;
  logic [31:0] qa = '0, qb = '0, ext = '0;
  logic rdy, ov, wr, m2, wm, rdy4, ov4, wr4, m24, wm4;
  logic [4:0] rd, rd4;
  logic [31:0] qbo, alu, qbo4, alu4;
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  exe_stage_mc dut (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(rdy), .ewreg(ewreg), .em2reg(em2reg),
    .ewmem(ewmem), .ealuimm(ealuimm), .ealuc(ealuc), .RdRtin(rdin), .qa(qa), .qb(qb),
    .extended(ext), .out_valid(ov), .wregout(wr), .m2regout(m2), .wmemout(wm),
    .RdRtout(rd), .qbout(qbo), .aluout(alu)
  );

  exe_stage_mc #(.MUL_BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(rdy4), .ewreg(ewreg), .em2reg(em2reg),
    .ewmem(ewmem), .ealuimm(ealuimm), .ealuc(ealuc), .RdRtin(rdin), .qa(qa), .qb(qb),
    .extended(ext), .out_valid(ov4), .wregout(wr4), .m2regout(m24), .wmemout(wm4),
    .RdRtout(rd4), .qbout(qbo4), .aluout(alu4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input logic [4:0] r);
    ealuc = c; qa = a; qb = b; rdin = r;
  endtask

  initial begin
    int cyc;
    logic stall_ok;
    tick(); tick();
    rst = 1'b0;
    chk("rst_ov", ov, 0); chk("rst_alu", alu, 0); chk("rst_rd", rd, 0);
    chk("rst_wr", wr, 0); chk("rst_rdy", rdy, 1);
    // ADD
    iv = 1; ewreg = 1; op(4'b0010, 5, 7, 3);
    tick();
    chk("add_ov", ov, 1); chk("add_alu", alu, 12); chk("add_wr", wr, 1); chk("add_rd", rd, 3);
    // SUB with immediate
    ealuimm = 1; ext = 32'h1; op(4'b0110, 0, 32'h55, 4);
    tick();
    chk("sub_alu", alu, 32'hFFFF_FFFF); chk("sub_ov", ov, 1); chk("sub_qbout", qbo, 32'h55);
    ealuimm = 0;
    op(4'b0111, 32'hFFFF_FFFF, 1, 4);
    tick();
    chk("slt_alu", alu, 1);
    op(4'b1010, 4, 32'h8000_0000, 4);
    tick();
    chk("sra_alu", alu, 32'hF800_0000);
    op(4'b1100, 32'hF0F0_0000, 32'h0000_00FF, 4);
    tick();
    chk("nor_alu", alu, 32'h0F0F_FF00);
    op(4'b0100, 32'h1234, 32'h5678, 8);
    tick();
    chk("undef_alu", alu, 0); chk("undef_wr", wr, 1); chk("undef_rd", rd, 8);
    // MUL, then MULHU held behind it
    op(4'b1101, 32'h10000, 32'h30000, 7);
    tick();
    chk("mul_e0_rdy", rdy, 0); chk("mul_e0_ov", ov, 0);
    op(4'b1110, 32'h10000, 32'h30000, 9);
    cyc = 0; stall_ok = 1;
    while (!ov && cyc < 100) begin
      if (!(rdy === 1'b0)) stall_ok = 0;
      tick(); cyc++;
    end
    chk("mul_lat", cyc, 32); chk("mul_stall", stall_ok, 1); chk("mul_alu", alu, 0);
    chk("mul_rd", rd, 7); chk("mul_wr", wr, 1); chk("mul_rdy_done", rdy, 1);
    tick();
    chk("mulhu_e0_ov", ov, 0); chk("mulhu_e0_rdy", rdy, 0);
    iv = 0;
    cyc = 0;
    while (!ov && cyc < 100) begin tick(); cyc++; end
    chk("mulhu_lat", cyc, 32); chk("mulhu_alu", alu, 3); chk("mulhu_rd", rd, 9);
    tick();
    chk("mulhu_after_ov", ov, 0);
    // four bits per cycle, ADD queued behind MULHU
    iv4 = 1; op(4'b1110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
    tick();
    chk("m4_e0_rdy", rdy4, 0);
    op(4'b0010, 5, 7, 6);
    cyc = 0;
    while (!ov4 && cyc < 100) begin tick(); cyc++; end
    chk("m4_lat", cyc, 8); chk("m4_alu", alu4, 32'hFFFF_FFFE); chk("m4_rd", rd4, 5);
    tick();
    chk("m4_add_ov", ov4, 1); chk("m4_add_alu", alu4, 12); chk("m4_add_rd", rd4, 6);
    iv4 = 0;
    tick();
    chk("m4_no_dup", ov4, 0);
    // reset mid-multiply
    iv = 1; op(4'b1101, 3, 5, 11);
    tick();
    iv = 0;
    repeat (10) tick();
    rst = 1;
    tick();
    rst = 0;
    chk("abort_ov", ov, 0); chk("abort_alu", alu, 0); chk("abort_rd", rd, 0);
    chk("abort_wr", wr, 0); chk("abort_qb", qbo, 0); chk("abort_rdy", rdy, 1);
    cyc = 0;
    repeat (40) begin tick(); if (ov) cyc++; end
    chk("abort_no_ov", cyc, 0);
    // store followed by idle cycle
    iv = 1; ewreg = 0; ewmem = 1; op(4'b0010, 1, 2, 2);
    tick();
    chk("st_wm", wm, 1); chk("st_ov", ov, 1); chk("st_alu", alu, 3);
    iv = 0;
    tick();
    chk("idle_wm", wm, 0); chk("idle_ov", ov, 0); chk("idle_alu", alu, 3); chk("idle_qb", qbo, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
